// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the buffered UART transmitter.
//   uart_tx_state_t : transmit FSM states (PARITY only reachable when
//                     UART_TX_PARITY_EN is defined).
//   LINE_IDLE       : serial line level while idle / during stop bits.
//   LINE_START      : serial line level during the start bit.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous DEPTH-entry, DATA_W-wide first-word-fall-through FIFO.
// Ports:
//   clk, rst         : clock, synchronous active-high reset (pointers cleared)
//   push, push_data  : write request; ignored while full
//   pop              : read request; ignored while empty
//   pop_data         : word at the head of the FIFO (valid while !empty)
//   full, empty      : status flags
//   level            : number of stored words, 0..DEPTH
module uart_fifo #(
  parameter int  DATA_W = 8,
  parameter int  DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [LVL_W-1:0]  level
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  count_q, count_d;
  logic              push_ok, pop_ok;

  assign full     = (count_q == LVL_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign level    = count_q;
  // The transmitter loads its shift register on the pop edge, so the head
  // word must be visible combinationally.
  assign pop_data = mem_q[rd_ptr_q];
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; contents are discarded by clearing the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered, parametrised UART transmitter.
// Words enter a DEPTH-entry FIFO via tx_valid/tx_ready and are serialised as
// start bit, DATA_W data bits LSB first, optional parity bit, STOP_BITS stop
// bits, each bit CLKS_PER_BIT clk cycles long.
// Build option: define UART_TX_PARITY_EN to include the parity bit
// (PARITY_ODD selects odd parity); undefined, frames carry no parity.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   en_tx       : allows new frames to start (never aborts a running frame)
//   data_tx     : word to enqueue, tx_valid qualifies it
//   tx_ready    : FIFO not full
//   u_tx        : registered serial output, idle high
//   tx_done     : one-cycle pulse after the last stop-bit cycle
//   busy        : frame in progress
//   fifo_level  : number of queued words
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int  DATA_W       = 8,
  parameter int  CLKS_PER_BIT = 16,
  parameter int  STOP_BITS    = 1,
  parameter int  DEPTH        = 4,
  parameter int  PARITY_ODD   = 0,
  localparam int LVL_W        = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_tx,
  input  logic [DATA_W-1:0] data_tx,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              u_tx,
  output logic              tx_done,
  output logic              busy,
  output logic [LVL_W-1:0]  fifo_level
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_W);

  // Reject illegal configurations at elaboration.
  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_tx_fifo: DATA_W must be 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two >= 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY_ODD must be 0 or 1");
  end

  uart_tx_state_t     state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               u_tx_q, u_tx_d;
  logic               tx_done_q, tx_done_d;
  logic               busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  logic               fifo_pop;
  logic               fifo_full, fifo_empty;
  logic [DATA_W-1:0]  fifo_data;
  logic               bit_end;
  logic               can_start;

  uart_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_valid),
    .push_data (data_tx),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign tx_ready  = !fifo_full;
  assign bit_end   = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign can_start = !fifo_empty && en_tx;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    u_tx_d    = u_tx_q;
    tx_done_d = 1'b0;
    fifo_pop  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    if (state_q != IDLE) baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);

    case (state_q)
      IDLE: begin
        if (can_start) begin
          state_d  = START;
          baud_d   = '0;
          bit_d    = '0;
          shift_d  = fifo_data;
          fifo_pop = 1'b1;
          u_tx_d   = LINE_START;
`ifdef UART_TX_PARITY_EN
          parity_d = (^fifo_data) ^ (PARITY_ODD != 0);
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          u_tx_d  = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_d = '0;
          if (bit_q == BIT_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            u_tx_d  = parity_q;
`else
            state_d = STOP;
            u_tx_d  = LINE_IDLE;
`endif
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_q >> 1;
            u_tx_d  = shift_d[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          bit_d   = '0;
          u_tx_d  = LINE_IDLE;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            tx_done_d = 1'b1;
            // Chain straight into the next frame when possible: no idle gap.
            if (can_start) begin
              state_d  = START;
              bit_d    = '0;
              shift_d  = fifo_data;
              fifo_pop = 1'b1;
              u_tx_d   = LINE_START;
`ifdef UART_TX_PARITY_EN
              parity_d = (^fifo_data) ^ (PARITY_ODD != 0);
`endif
            end else begin
              state_d = IDLE;
              u_tx_d  = LINE_IDLE;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        u_tx_d  = LINE_IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      u_tx_q    <= LINE_IDLE;
      tx_done_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      u_tx_q    <= u_tx_d;
      tx_done_q <= tx_done_d;
      busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign u_tx    = u_tx_q;
  assign tx_done = tx_done_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo.
// dut_a: 8-bit, 4 clocks/bit, 1 stop bit, even parity (when compiled in).
// dut_b: 8-bit, 4 clocks/bit, 2 stop bits, odd parity (when compiled in).
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH + 1);
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NBITS_A = 2 + DW + P;
  localparam int FRAME_A = CPB * (1 + DW + P + 1);
  localparam int FRAME_B = CPB * (1 + DW + P + 2);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             a_en = 1'b1, a_valid = 1'b0;
  logic [DW-1:0]    a_data = '0;
  logic             a_ready, a_u_tx, a_done, a_busy;
  logic [LVL_W-1:0] a_level;

  logic             b_en = 1'b1, b_valid = 1'b0;
  logic [DW-1:0]    b_data = '0;
  logic             b_ready, b_u_tx, b_done, b_busy;
  logic [LVL_W-1:0] b_level;

  uart_tx_fifo #(
    .DATA_W(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .DEPTH(DEPTH), .PARITY_ODD(0)
  ) dut_a (
    .clk(clk), .rst(rst), .en_tx(a_en), .data_tx(a_data), .tx_valid(a_valid),
    .tx_ready(a_ready), .u_tx(a_u_tx), .tx_done(a_done), .busy(a_busy),
    .fifo_level(a_level)
  );

  uart_tx_fifo #(
    .DATA_W(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .DEPTH(DEPTH), .PARITY_ODD(1)
  ) dut_b (
    .clk(clk), .rst(rst), .en_tx(b_en), .data_tx(b_data), .tx_valid(b_valid),
    .tx_ready(b_ready), .u_tx(b_u_tx), .tx_done(b_done), .busy(b_busy),
    .fifo_level(b_level)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait expired, expected condition never reached (cycle %0d)", name, cyc);
  endtask

  // Vector table: line[10] is sent first: start, d0..d7, even parity, stop.
  typedef struct {
    logic [7:0]  data;
    logic [10:0] line;
  } vec_t;
  vec_t vecs[6];

  // Scoreboard of words accepted by dut_a, in send order.
  logic [DW-1:0] exp_q[$];
  int            rst_epoch = 0;
  int            a_done_cnt = 0;
  int            a_peak = 0;

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  // with tx_valid still asserted.
  task automatic push_a(input logic [DW-1:0] d);
    int n;
    n = 0;
    a_valid = 1'b1;
    a_data  = d;
    forever begin
      #4;
      if (a_ready === 1'b1) begin
        exp_q.push_back(d);
        @(posedge clk);
        @(negedge clk);
        break;
      end
      @(negedge clk);
      n++;
      if (n > 100) begin
        timeout("push_a_ready");
        break;
      end
    end
  endtask

  task automatic wait_idle_a(input int budget);
    int n;
    n = 0;
    while (!(a_busy === 1'b0 && a_level == 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) timeout("a_idle");
  endtask

  // Passive status monitor for dut_a.
  initial begin
    forever begin
      @(negedge clk);
      if (a_done === 1'b1) a_done_cnt++;
      if (int'(a_level) > a_peak) a_peak = int'(a_level);
    end
  end

  // Line decoder for dut_a: recovers each frame from u_tx and compares it
  // with the scoreboard head. Frames cut short by reset are dropped.
  logic          mon_prev = 1'b1;
  logic [DW-1:0] mon_w, mon_e;
  logic          mon_par, mon_stop;
  int            mon_ep;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_prev && a_u_tx === 1'b0 && rst === 1'b0) begin
        mon_ep = rst_epoch;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < DW; i++) begin
          repeat (CPB) @(negedge clk);
          mon_w[i] = a_u_tx;
        end
        mon_par = 1'b0;
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        mon_par = a_u_tx;
`endif
        repeat (CPB) @(negedge clk);
        mon_stop = a_u_tx;
        if (mon_ep == rst_epoch) begin
          if (exp_q.size() == 0) begin
            timeout("sb_unexpected_frame");
          end else begin
            mon_e = exp_q.pop_front();
            check("sb_data", 32'(mon_w), 32'(mon_e));
            check("sb_stop", 32'(mon_stop), 32'd1);
`ifdef UART_TX_PARITY_EN
            check("sb_parity_even", 32'(mon_par), 32'(^mon_e));
`endif
          end
        end
      end
      mon_prev = (a_u_tx !== 1'b0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  int start_c, sb, hi, cnt, done_before;
  logic exp_bit;

  initial begin
    vecs[0] = '{8'hA5, 11'b0_10100101_0_1};
    vecs[1] = '{8'h00, 11'b0_00000000_0_1};
    vecs[2] = '{8'hFF, 11'b0_11111111_0_1};
    vecs[3] = '{8'h3C, 11'b0_00111100_0_1};
    vecs[4] = '{8'h81, 11'b0_10000001_0_1};
    vecs[5] = '{8'h07, 11'b0_11100000_1_1};

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_u_tx", 32'(a_u_tx), 32'd1);
    check("rst_tx_done", 32'(a_done), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_level", 32'(a_level), 32'd0);
    check("rst_tx_ready", 32'(a_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Single frames from the vector table.
    for (int v = 0; v < 6; v++) begin
      wait_idle_a(500);
      push_a(vecs[v].data);
      a_valid = 1'b0;
      @(negedge clk);
      start_c = cyc;
      check("frame_latency_start_low", 32'(a_u_tx), 32'd0);
      for (int b = 0; b < NBITS_A; b++) begin
        wait_cyc(start_c + CPB * b + CPB / 2);
        exp_bit = (b == NBITS_A - 1) ? vecs[v].line[0] : vecs[v].line[10 - b];
        check($sformatf("frame%0d_bit%0d", v, b), 32'(a_u_tx), 32'(exp_bit));
      end
      wait_cyc(start_c + FRAME_A - 1);
      check("frame_done_before", 32'(a_done), 32'd0);
      wait_cyc(start_c + FRAME_A);
      check("frame_done_pulse", 32'(a_done), 32'd1);
      wait_cyc(start_c + FRAME_A + 1);
      check("frame_done_after", 32'(a_done), 32'd0);
    end

    // Back-to-back: four words on consecutive cycles.
    wait_idle_a(500);
    a_peak = 0;
    done_before = a_done_cnt;
    for (int i = 1; i <= 4; i++) push_a(vecs[i].data);
    a_valid = 1'b0;
    start_c = cyc - 2;
    for (int k = 0; k < 4; k++) begin
      wait_cyc(start_c + (k + 1) * FRAME_A);
      check("b2b_done_spacing", 32'(a_done), 32'd1);
      check("b2b_busy_no_gap", 32'(a_busy), (k < 3) ? 32'd1 : 32'd0);
    end
    wait_idle_a(500);
    check("b2b_level_peak", 32'(a_peak), 32'd3);
    check("b2b_done_count", 32'(a_done_cnt - done_before), 32'd4);
    repeat (4) @(negedge clk);
    check("b2b_scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // Full FIFO with transmission disabled.
    a_en = 1'b0;
    @(negedge clk);
    push_a(8'h11);
    push_a(8'h22);
    push_a(8'h33);
    push_a(8'h44);
    check("full_tx_ready", 32'(a_ready), 32'd0);
    check("full_level", 32'(a_level), 32'd4);
    a_data = 8'h55;
    repeat (3) @(negedge clk);
    check("full_hold_ready", 32'(a_ready), 32'd0);
    check("full_hold_level", 32'(a_level), 32'd4);
    a_en = 1'b1;
    @(negedge clk);
    check("full_pop_level", 32'(a_level), 32'd3);
    check("full_pop_ready", 32'(a_ready), 32'd1);
    exp_q.push_back(8'h55);
    @(negedge clk);
    a_valid = 1'b0;
    check("full_fifth_accepted", 32'(a_level), 32'd4);
    wait_idle_a(1000);
    repeat (4) @(negedge clk);
    check("full_scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of DATA with two words queued.
    push_a(8'hC3);
    push_a(8'h96);
    push_a(8'h3A);
    a_valid = 1'b0;
    start_c = cyc - 1;
    wait_cyc(start_c + CPB * 4 + 1);
    check("rst_mid_pre_level", 32'(a_level), 32'd2);
    check("rst_mid_pre_busy", 32'(a_busy), 32'd1);
    rst_epoch++;
    exp_q.delete();
    done_before = a_done_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_u_tx", 32'(a_u_tx), 32'd1);
    check("rst_mid_busy", 32'(a_busy), 32'd0);
    check("rst_mid_level", 32'(a_level), 32'd0);
    check("rst_mid_ready", 32'(a_ready), 32'd1);
    rst = 1'b0;
    repeat (2 * FRAME_A) @(negedge clk);
    check("rst_mid_no_done", 32'(a_done_cnt - done_before), 32'd0);
    check("rst_mid_line_idle", 32'(a_u_tx), 32'd1);

    // dut_b: 2 stop bits, en_tx dropped mid-frame.
    @(negedge clk);
    b_valid = 1'b1;
    b_data  = 8'h07;
    @(negedge clk);
    b_data = 8'h5A;
    @(negedge clk);
    b_valid = 1'b0;
    sb = cyc;
    check("b_start_low", 32'(b_u_tx), 32'd0);
    check("b_level_queued", 32'(b_level), 32'd1);
    wait_cyc(sb + 6);
    b_en = 1'b0;
    for (int i = 0; i < DW; i++) begin
      wait_cyc(sb + CPB * (1 + i) + CPB / 2);
      check($sformatf("b_data_bit%0d", i), 32'(b_u_tx), (i < 3) ? 32'd1 : 32'd0);
    end
`ifdef UART_TX_PARITY_EN
    wait_cyc(sb + CPB * (1 + DW) + CPB / 2);
    check("b_parity_odd", 32'(b_u_tx), 32'd0);
`endif
    hi = 0;
    for (int c = 0; c < 2 * CPB; c++) begin
      wait_cyc(sb + CPB * (1 + DW + P) + c);
      if (b_u_tx === 1'b1 && b_busy === 1'b1 && b_done === 1'b0) hi++;
    end
    check("b_two_stop_bits_high", 32'(hi), 32'd8);
    wait_cyc(sb + FRAME_B);
    check("b_done_pulse", 32'(b_done), 32'd1);
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (b_u_tx === 1'b1 && b_busy === 1'b0 && b_level == 1 && b_done === 1'b0) cnt++;
    end
    check("b_held_while_disabled", 32'(cnt), 32'd20);
    b_en = 1'b1;
    @(negedge clk);
    check("b_restart_start_low", 32'(b_u_tx), 32'd0);
    check("b_restart_level", 32'(b_level), 32'd0);
    wait_cyc(sb + 20 + FRAME_B + 1 + FRAME_B);
    check("b_second_done", 32'(b_done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
